card_request_arbiter: RTL and testbench
=======================================

// Module: card_request_arbiter
// PURPOSE
//  Sequences the seed_random_1_data_path card generator and shares it between N_REQ requesters (players, dealer).
//  Grants one requester at a time, round-robin. Pulses req_card_state_dp_o, waits DP_LAT cycles, then samples the card.
//  Rejects out-of-range cards by re-requesting. Returns one card per grant with an ack pulse.
//  Sits between the game FSM (requesters) and the random-card datapath.
// PARAMETERS
//  N_REQ      2   number of requesters (2..8)
//  DP_LAT     2   cycles from req_card_state_dp_o pulse to valid card_to_send_dp_i (1..15)
//  MAX_RETRY  15  re-requests allowed per grant before error delivery (1..255)
// PORTS
//  clk_arb_i            in   1      clock, rising edge
//  rst_arb_i            in   1      synchronous reset, active-high
//  req_i                in   N_REQ  level request per requester; held until its ack_o bit pulses
//  ack_o                out  N_REQ  one-cycle pulse, one-hot, to the served requester
//  card_o               out  8      delivered card, valid only in the ack_o cycle
//  err_o                out  1      pulses with ack_o when card_o = 8'hFF (retries exhausted or deck empty)
//  busy_o               out  1      high in every state except IDLE
//  shuffle_i            in   1      pulse: start a new deck (clears used mask, if compiled in)
//  deck_empty_o         out  1      all 52 cards dealt (with macro only)
//  req_card_state_dp_o  out  1      to datapath: one-cycle request pulse
//  card_to_send_dp_i    in   8      from datapath: card code; valid 0..51, anything else invalid
// BEHAVIOUR
//  Reset values: ack_o=0, card_o=0, err_o=0, busy_o=0, req_card_state_dp_o=0, deck_empty_o=0, used mask=0,
//   rr pointer=N_REQ-1 (requester 0 wins first), retry count=0, FSM in IDLE.
//  FSM states: IDLE, ISSUE, WAIT, CHECK, DELIVER.
//   IDLE: if any req_i bit is set, latch grant = first set bit after the rr pointer (wrapping) -> ISSUE. Otherwise stay.
//   ISSUE: req_card_state_dp_o=1 for exactly this cycle; load wait counter with DP_LAT-1 -> WAIT.
//   WAIT: count down; on 0 -> CHECK. The sample is taken exactly DP_LAT cycles after the ISSUE cycle.
//   CHECK: register card_to_send_dp_i. Card is bad if >51 (or a duplicate, with macro).
//    If bad and retry<MAX_RETRY: retry++ -> ISSUE.
//    If bad and retry==MAX_RETRY: deliver 8'hFF with err_o -> DELIVER.
//    If good: mark card used (macro) -> DELIVER.
//   DELIVER: ack_o[grant]=1 and card_o valid for 1 cycle; rr pointer=grant; retry=0 -> IDLE.
//  Minimum latency for a good card on the first try: grant in the IDLE cycle, ack after DP_LAT+3 cycles.
//   With back-to-back requests, IDLE takes 1 cycle between services.
//  Grant is locked from IDLE to DELIVER. Dropping req_i mid-service does not abort the service; the ack still pulses.
//  Simultaneous requests: round-robin only, no starvation.
//   Example, N_REQ=2, both requesters held: grant order 0,1,0,1...
//  shuffle_i: takes effect in the cycle it is sampled, in any state.
//   If it arrives during CHECK, the current card is checked against the already-cleared mask.
//  Reset mid-operation: return to IDLE immediately. No ack is issued for the in-flight grant.
//   The datapath request pulse is dropped the same cycle.
// CONFIGURATION
//  DUP_REJECT_EN defined:
//   52-bit used mask; a card already in the mask counts as bad and is retried.
//   deck_empty_o = (popcount(mask)==52).
//   While deck_empty_o is set, a grant skips ISSUE: IDLE -> DELIVER with card_o=8'hFF and err_o=1.
//   shuffle_i clears the mask.
//  DUP_REJECT_EN undefined: no mask is built; only the >51 check applies; deck_empty_o is tied to 0;
//   shuffle_i is ignored.
// TESTING
//  1. Reset, req_i=2'b01, model returns 8'd17 -> req_card_state_dp_o pulses once; ack_o=2'b01 with card_o=17,
//     DP_LAT+3 cycles after the request.
//  2. req_i=2'b11 held, model returns 3,4,5,6 -> acks alternate 01,10,01,10 with cards 3,4,5,6.
//  3. Model returns 8'd60 twice, then 8'd9 -> three datapath pulses; single ack with card_o=9; err_o=0.
//  4. MAX_RETRY=2, model always returns 8'hC8 -> three pulses, then ack with card_o=8'hFF and err_o=1.
//  5. DUP_REJECT_EN: 52 distinct cards dealt, then a duplicate is offered -> duplicate retried; deck_empty_o=1;
//     the next request acks 8'hFF with err_o=1 and no datapath pulse; shuffle_i clears deck_empty_o.
//  6. Assert rst_arb_i during WAIT -> next cycle busy_o=0, ack_o=0; next service goes to requester 0.

Source files
------------

// File: rtl/card_request_arbiter.sv
// Purpose: round-robin share of the random-card datapath between N_REQ requesters, with range and duplicate rejection.
// Latency: ack DP_LAT+3 cycles after a grant on a good first card; each re-request adds DP_LAT+2 cycles.
// Backpressure: level requests are held until ack; one service at a time; grant locked until DELIVER.
//
// Ports: clk_arb_i/rst_arb_i (sync active-high reset); req_i/ack_o requester handshake; card_o/err_o result
// (valid in ack cycle); busy_o; shuffle_i/deck_empty_o deck control; req_card_state_dp_o/card_to_send_dp_i datapath.
// Optional feature macro: DUP_REJECT_EN (52-card used mask, duplicate rejection, deck_empty_o, shuffle_i).
module card_request_arbiter #(
    parameter int N_REQ     = 2,
    parameter int DP_LAT    = 2,
    parameter int MAX_RETRY = 15
) (
    input  logic             clk_arb_i,
    input  logic             rst_arb_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] ack_o,
    output logic [7:0]       card_o,
    output logic             err_o,
    output logic             busy_o,
    input  logic             shuffle_i,
    output logic             deck_empty_o,
    output logic             req_card_state_dp_o,
    input  logic [7:0]       card_to_send_dp_i
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, DELIVER} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   grant_q, rr_q, grant_sel;
    logic            any_req, found;
    logic [3:0]      wait_q;
    logic [7:0]      retry_q, sample_q, dcard_q;
    logic            derr_q;
    logic            card_bad, deck_empty_eff;

    // First requester strictly after the round-robin pointer, wrapping.
    always_comb begin
        grant_sel = rr_q;
        found     = 1'b0;
        any_req   = |req_i;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!found && req_i[(int'(rr_q) + i) % N_REQ]) begin
                grant_sel = PW'((int'(rr_q) + i) % N_REQ);
                found     = 1'b1;
            end
        end
    end

`ifdef DUP_REJECT_EN
    logic [51:0] used_q, used_eff;

    // A shuffle clears the mask in the very cycle it is seen, so a card
    // under CHECK in that cycle is judged against an empty deck.
    assign used_eff       = shuffle_i ? '0 : used_q;
    assign deck_empty_eff = &used_eff;
    assign deck_empty_o   = &used_q;
    assign card_bad       = (sample_q > 8'd51) || used_eff[sample_q[5:0]];

    always_ff @(posedge clk_arb_i) begin
        if (rst_arb_i)
            used_q <= '0;
        else if (state_q == CHECK && !card_bad)
            used_q <= used_eff | (52'd1 << sample_q[5:0]);
        else
            used_q <= used_eff;
    end
`else
    logic unused_shuffle;

    assign unused_shuffle = shuffle_i;
    assign deck_empty_eff = 1'b0;
    assign deck_empty_o   = 1'b0;
    assign card_bad       = (sample_q > 8'd51);
`endif

    // State register
    always_ff @(posedge clk_arb_i) begin
        if (rst_arb_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = deck_empty_eff ? DELIVER : ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (wait_q == 4'd0) state_d = CHECK;
            CHECK:   state_d = (card_bad && retry_q < 8'(MAX_RETRY)) ? ISSUE : DELIVER;
            DELIVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant, pointer, retry and card registers
    always_ff @(posedge clk_arb_i) begin
        if (rst_arb_i) begin
            grant_q  <= '0;
            rr_q     <= PW'(N_REQ - 1);
            retry_q  <= '0;
            wait_q   <= '0;
            sample_q <= '0;
            dcard_q  <= '0;
            derr_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= grant_sel;
                        // Empty deck: skip the datapath and report the error card.
                        if (deck_empty_eff) begin
                            dcard_q <= 8'hFF;
                            derr_q  <= 1'b1;
                        end
                    end
                end
                ISSUE: wait_q <= 4'(DP_LAT - 1);
                WAIT: begin
                    // Last WAIT cycle is DP_LAT cycles after ISSUE: capture the card here.
                    if (wait_q != 4'd0)
                        wait_q <= wait_q - 4'd1;
                    else
                        sample_q <= card_to_send_dp_i;
                end
                CHECK: begin
                    if (card_bad) begin
                        if (retry_q < 8'(MAX_RETRY)) begin
                            retry_q <= retry_q + 8'd1;
                        end else begin
                            dcard_q <= 8'hFF;
                            derr_q  <= 1'b1;
                        end
                    end else begin
                        dcard_q <= sample_q;
                        derr_q  <= 1'b0;
                    end
                end
                DELIVER: begin
                    rr_q    <= grant_q;
                    retry_q <= '0;
                end
                default: ;
            endcase
        end
    end

    // Outputs; pulses are masked by reset so an in-flight service is dropped at once.
    always_comb begin
        busy_o              = (state_q != IDLE);
        req_card_state_dp_o = (state_q == ISSUE) && !rst_arb_i;
        ack_o               = '0;
        card_o              = 8'd0;
        err_o               = 1'b0;
        if (state_q == DELIVER && !rst_arb_i) begin
            ack_o  = N_REQ'(1) << grant_q;
            card_o = dcard_q;
            err_o  = derr_q;
        end
    end

endmodule

// File: tb/tb_card_request_arbiter.sv
module tb_card_request_arbiter;

    localparam int N   = 2;
    localparam int LAT = 2;
    localparam int MR  = 2;

    typedef struct {
        logic [1:0] ack;
        logic [7:0] card;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [1:0] ack;
    logic [7:0] card;
    logic       err, busy, shuffle, deck_empty, dp_req;
    logic [7:0] dp_dat;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   pulses = 0;
    int   dp_cd  = -1;

    exp_t       sb[$];
    logic [7:0] dp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    card_request_arbiter #(.N_REQ(N), .DP_LAT(LAT), .MAX_RETRY(MR)) dut (
        .clk_arb_i(clk), .rst_arb_i(rst), .req_i(req), .ack_o(ack), .card_o(card),
        .err_o(err), .busy_o(busy), .shuffle_i(shuffle), .deck_empty_o(deck_empty),
        .req_card_state_dp_o(dp_req), .card_to_send_dp_i(dp_dat));

    // Datapath model: card valid only in the cycle LAT after the request pulse, garbage otherwise.
    always @(negedge clk) begin
        dp_dat = 8'hEE;
        if (dp_cd > 0) begin
            dp_cd--;
            if (dp_cd == 0 && dp_q.size() > 0) dp_dat = dp_q.pop_front();
        end
        if (dp_req === 1'b1) begin
            pulses++;
            dp_cd = LAT;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (ack !== 2'b00) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: ack=%b card=%0d err=%b, required no ack", ack, card, err);
            end else begin
                e = sb.pop_front();
                if (ack !== e.ack || card !== e.card || err !== e.err) begin
                    errors++;
                    $display("FAIL scoreboard: ack=%b card=%0d err=%b, required ack=%b card=%0d err=%b",
                             ack, card, err, e.ack, e.card, e.err);
                end
            end
        end
    end

    task automatic push_exp(input logic [1:0] a, input logic [7:0] c, input logic e);
        exp_t x;
        x.ack = a; x.card = c; x.err = e;
        sb.push_back(x);
    endtask

    // Holds r until n acks have been seen (bounded), then drops it before the next edge.
    task automatic run(input logic [1:0] r, input int n, output int got, output int start_cyc, output int last_cyc);
        @(posedge clk); #1;
        req       = r;
        start_cyc = cyc;
        last_cyc  = -1;
        got       = 0;
        for (int k = 0; k < 300 && got < n; k++) begin
            @(negedge clk);
            if (ack !== 2'b00) begin
                got++;
                last_cyc = cyc;
            end
        end
        req = 2'b00;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b00; shuffle = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks += 6;
        if (ack !== 2'b00)    begin errors++; $display("FAIL reset_ack: got %b want 00", ack); end
        if (card !== 8'd0)    begin errors++; $display("FAIL reset_card: got %0d want 0", card); end
        if (err !== 1'b0)     begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (dp_req !== 1'b0)  begin errors++; $display("FAIL reset_dp_req: got %b want 0", dp_req); end
        if (deck_empty !== 1'b0) begin errors++; $display("FAIL reset_deck_empty: got %b want 0", deck_empty); end
    endtask

    task automatic test_single();
        int got, s, l, p0;
        p0 = pulses;
        dp_q.push_back(8'd17);
        push_exp(2'b01, 8'd17, 1'b0);
        run(2'b01, 1, got, s, l);
        checks += 3;
        if (got !== 1)             begin errors++; $display("FAIL single_timeout: acks %0d want 1", got); end
        if (l - s !== LAT + 3)     begin errors++; $display("FAIL single_latency: got %0d want %0d", l - s, LAT + 3); end
        if (pulses - p0 !== 1)     begin errors++; $display("FAIL single_pulses: got %0d want 1", pulses - p0); end
    endtask

    task automatic test_round_robin();
        int got, s, l;
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            dp_q.push_back(8'(3 + i));
            push_exp((i % 2 == 0) ? 2'b01 : 2'b10, 8'(3 + i), 1'b0);
        end
        run(2'b11, 4, got, s, l);
        checks += 2;
        if (got !== 4)                  begin errors++; $display("FAIL rr_timeout: acks %0d want 4", got); end
        if (l - s !== 4 * (LAT + 4) - 1) begin errors++; $display("FAIL rr_back_to_back: got %0d want %0d", l - s, 4 * (LAT + 4) - 1); end
    endtask

    task automatic test_retry();
        int got, s, l, p0;
        p0 = pulses;
        dp_q.push_back(8'd60); dp_q.push_back(8'd60); dp_q.push_back(8'd9);
        push_exp(2'b01, 8'd9, 1'b0);
        run(2'b01, 1, got, s, l);
        checks += 3;
        if (got !== 1)                      begin errors++; $display("FAIL retry_timeout: acks %0d want 1", got); end
        if (pulses - p0 !== 3)              begin errors++; $display("FAIL retry_pulses: got %0d want 3", pulses - p0); end
        if (l - s !== LAT + 3 + 2 * (LAT + 2)) begin errors++; $display("FAIL retry_latency: got %0d want %0d", l - s, LAT + 3 + 2 * (LAT + 2)); end
    endtask

    task automatic test_retry_exhaust();
        int got, s, l, p0;
        p0 = pulses;
        repeat (3) dp_q.push_back(8'hC8);
        push_exp(2'b01, 8'hFF, 1'b1);
        run(2'b01, 1, got, s, l);
        repeat (4) @(negedge clk);
        checks += 2;
        if (got !== 1)         begin errors++; $display("FAIL exhaust_timeout: acks %0d want 1", got); end
        if (pulses - p0 !== 3) begin errors++; $display("FAIL exhaust_pulses: got %0d want 3", pulses - p0); end
    endtask

`ifdef DUP_REJECT_EN
    task automatic test_dup();
        int got, s, l, p0, tot;
        p0 = pulses; tot = 0;
        for (int c = 0; c < 51; c++) begin
            dp_q.push_back(8'(c));
            push_exp(2'b01, 8'(c), 1'b0);
            run(2'b01, 1, got, s, l);
            tot += got;
        end
        checks += 2;
        if (tot !== 51)         begin errors++; $display("FAIL dup_fill: acks %0d want 51", tot); end
        if (pulses - p0 !== 51) begin errors++; $display("FAIL dup_fill_pulses: got %0d want 51", pulses - p0); end
        p0 = pulses;
        dp_q.push_back(8'd5); dp_q.push_back(8'd51);
        push_exp(2'b01, 8'd51, 1'b0);
        run(2'b01, 1, got, s, l);
        @(negedge clk);
        checks += 3;
        if (got !== 1)           begin errors++; $display("FAIL dup_last_timeout: acks %0d want 1", got); end
        if (pulses - p0 !== 2)   begin errors++; $display("FAIL dup_retry_pulses: got %0d want 2", pulses - p0); end
        if (deck_empty !== 1'b1) begin errors++; $display("FAIL deck_empty_set: got %b want 1", deck_empty); end
        p0 = pulses;
        push_exp(2'b01, 8'hFF, 1'b1);
        run(2'b01, 1, got, s, l);
        checks += 3;
        if (got !== 1)         begin errors++; $display("FAIL empty_timeout: acks %0d want 1", got); end
        if (pulses - p0 !== 0) begin errors++; $display("FAIL empty_pulses: got %0d want 0", pulses - p0); end
        if (l - s !== 1)       begin errors++; $display("FAIL empty_latency: got %0d want 1", l - s); end
        @(posedge clk); #1 shuffle = 1'b1;
        @(posedge clk); #1 shuffle = 1'b0;
        @(negedge clk);
        checks++;
        if (deck_empty !== 1'b0) begin errors++; $display("FAIL shuffle_clear: got %b want 0", deck_empty); end
    endtask
`else
    task automatic test_no_dup();
        int got, s, l, p0;
        p0 = pulses;
        for (int i = 0; i < 2; i++) begin
            dp_q.push_back(8'd17);
            push_exp(2'b01, 8'd17, 1'b0);
            run(2'b01, 1, got, s, l);
            checks++;
            if (got !== 1) begin errors++; $display("FAIL nodup_timeout: acks %0d want 1", got); end
        end
        @(posedge clk); #1 shuffle = 1'b1;
        @(posedge clk); #1 shuffle = 1'b0;
        @(negedge clk);
        checks += 2;
        if (pulses - p0 !== 2)   begin errors++; $display("FAIL nodup_pulses: got %0d want 2", pulses - p0); end
        if (deck_empty !== 1'b0) begin errors++; $display("FAIL nodup_deck_empty: got %b want 0", deck_empty); end
    endtask
`endif

    task automatic test_reset_mid();
        int got, s, l, k;
        @(posedge clk); #1 req = 2'b01;
        for (k = 0; k < 20 && dp_req !== 1'b1; k++) @(negedge clk);
        checks++;
        if (dp_req !== 1'b1) begin errors++; $display("FAIL midreset_no_pulse: dp_req %b want 1", dp_req); end
        @(posedge clk); #1 rst = 1'b1; req = 2'b00;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks += 2;
        if (busy !== 1'b0)  begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
        if (ack !== 2'b00)  begin errors++; $display("FAIL midreset_ack: got %b want 00", ack); end
        repeat (6) @(negedge clk);
        dp_q.push_back(8'd20);
        push_exp(2'b01, 8'd20, 1'b0);
        run(2'b11, 1, got, s, l);
        checks++;
        if (got !== 1) begin errors++; $display("FAIL midreset_timeout: acks %0d want 1", got); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_retry();
        test_retry_exhaust();
`ifdef DUP_REJECT_EN
        test_dup();
`else
        test_no_dup();
`endif
        test_reset_mid();
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: %0d left, want 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
